key_scan_decoder: RTL

Parametrised keypad front end for the whack-a-mole game. It takes a raw key-down level and a {column,row} position code, and debounces them with a state machine. It then emits a registered linear key number (row*COLS+col), a held-valid level, one-cycle press pulses with optional auto-repeat, and an error pulse for out-of-range positions. It sits between the board keypad inputs and the game controller, which consumes key_press/key_number.

---
 rtl/key_pkg.sv | 27 ++
 rtl/key_index_decoder.sv | 27 ++
 rtl/key_scan_decoder.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared state encoding, width helpers and invalid-key constant for the keypad front end
package key_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_HELD    = 2'd2,
        ST_RELEASE = 2'd3
    } key_state_e;

    // Sliced down to the key-number width by each user; all-ones never collides with a real index.
    localparam logic [31:0] KEY_INVALID_ALL = '1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int max1(input int v);
        return (v < 1) ? 1 : v;
    endfunction

endpackage

// File: rtl/key_index_decoder.sv
// rtl/key_index_decoder.sv - combinational {col,row} to linear key index with range check
module key_index_decoder
    import key_pkg::*;
#(
    parameter int ROWS = 3,
    parameter int COLS = 3,
    localparam int RW = max1(clog2(ROWS)),
    localparam int CW = max1(clog2(COLS)),
    localparam int NW = clog2(ROWS * COLS + 1)
) (
    input  logic [CW+RW-1:0] code,
    output logic [NW-1:0]    number,
    output logic             in_range
);

    localparam logic [31:0] ROWS_U = 32'(ROWS);
    localparam logic [31:0] COLS_U = 32'(COLS);

    logic [RW-1:0] row;
    logic [CW-1:0] col;

    assign row      = code[RW-1:0];
    assign col      = code[CW+RW-1:RW];
    assign in_range = (32'(row) < ROWS_U) && (32'(col) < COLS_U);
    assign number   = NW'(32'(row) * COLS_U + 32'(col));

endmodule

// File: rtl/key_scan_decoder.sv
// rtl/key_scan_decoder.sv - debounced keypad scanner with press pulses, auto-repeat and range errors
module key_scan_decoder
    import key_pkg::*;
#(
    parameter int ROWS            = 3,
    parameter int COLS            = 3,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_CYCLES   = 0,
    localparam int RW = max1(clog2(ROWS)),
    localparam int CW = max1(clog2(COLS)),
    localparam int NW = clog2(ROWS * COLS + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             key_down,
    input  logic [CW+RW-1:0] key_code,
    output logic [NW-1:0]    key_number,
    output logic             key_valid,
    output logic             key_press,
    output logic             key_error
);

    localparam int KW  = CW + RW;
    localparam int CNW = max1(clog2(DEBOUNCE_CYCLES));
    localparam int RPW = max1(clog2(REPEAT_CYCLES));
    localparam logic [CNW-1:0] CNT_LAST  = CNW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPW-1:0] RPT_LAST  = RPW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
    localparam logic [NW-1:0]  INVALID   = KEY_INVALID_ALL[NW-1:0];
    localparam bit             REPEAT_EN = (REPEAT_CYCLES > 0);

    key_state_e     state, state_d;
    logic [KW-1:0]  cand, cand_d;
    logic [CNW-1:0] cnt, cnt_d;
    logic [RPW-1:0] rpt, rpt_d;
    logic [NW-1:0]  number_d;
    logic           valid_d, press_d, error_d;
    logic [NW-1:0]  dec_number;
    logic           dec_in_range;
    logic           stay, accept, rpt_fire, rel_done;

    key_index_decoder #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_index (
        .code     (cand),
        .number   (dec_number),
        .in_range (dec_in_range)
    );

    // "stay" means the sample still matches the candidate key being debounced or held.
    assign stay     = key_down && (key_code == cand);
    assign accept   = (state == ST_SETTLE) && stay && (cnt == CNT_LAST);
    assign rpt_fire = (state == ST_HELD) && stay && REPEAT_EN && key_valid && (rpt == RPT_LAST);
    assign rel_done = (state == ST_RELEASE) && !stay && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            cand       <= '0;
            cnt        <= '0;
            rpt        <= '0;
            key_number <= INVALID;
            key_valid  <= 1'b0;
            key_press  <= 1'b0;
            key_error  <= 1'b0;
        end else begin
            state      <= state_d;
            cand       <= cand_d;
            cnt        <= cnt_d;
            rpt        <= rpt_d;
            key_number <= number_d;
            key_valid  <= valid_d;
            key_press  <= press_d;
            key_error  <= error_d;
        end
    end

    always_comb begin
        state_d = state;
        cand_d  = cand;
        cnt_d   = cnt;
        rpt_d   = rpt;
        case (state)
            ST_IDLE: begin
                if (key_down) begin
                    state_d = ST_SETTLE;
                    cand_d  = key_code;
                    cnt_d   = CNW'(1);
                end
            end
            ST_SETTLE: begin
                if (!key_down) begin
                    state_d = ST_IDLE;
                end else if (key_code != cand) begin
                    cand_d = key_code;
                    cnt_d  = CNW'(1);
                end else if (cnt == CNT_LAST) begin
                    state_d = ST_HELD;
                    rpt_d   = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            ST_HELD: begin
                if (!stay) begin
                    state_d = ST_RELEASE;
                    cnt_d   = CNW'(1);
                end else if (REPEAT_EN && key_valid) begin
                    rpt_d = (rpt == RPT_LAST) ? '0 : rpt + 1'b1;
                end
            end
            ST_RELEASE: begin
                // A matching sample here is contact bounce: resume holding, repeat phase kept.
                if (stay) begin
                    state_d = ST_HELD;
                end else if (cnt == CNT_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        number_d = key_number;
        valid_d  = key_valid;
        press_d  = 1'b0;
        error_d  = 1'b0;
        if (accept) begin
            if (dec_in_range) begin
                number_d = dec_number;
                valid_d  = 1'b1;
                press_d  = 1'b1;
            end else begin
                number_d = INVALID;
                valid_d  = 1'b0;
                error_d  = 1'b1;
            end
        end
        if (rpt_fire) press_d = 1'b1;
        if (rel_done) begin
            number_d = INVALID;
            valid_d  = 1'b0;
        end
    end

endmodule
